// File: rtl/layer_output_collector_if.sv
// layer_output_collector_if: neuron lane inputs and frame valid/ready output bus.
// slave is the collector side; master is the neuron/downstream side.
interface layer_output_collector_if #(
   parameter int NUM_NEURONS = 5,
   parameter int DATA_WIDTH  = 23
);
   logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data;
   logic [NUM_NEURONS-1:0]            in_valid;
   logic [NUM_NEURONS*DATA_WIDTH-1:0] frame_data;
   logic                              frame_valid;
   logic                              frame_ready;
   modport master (output in_data, in_valid, frame_ready, input frame_data, frame_valid);
   modport slave  (input in_data, in_valid, frame_ready, output frame_data, frame_valid);
endinterface

// File: rtl/layer_output_collector.sv
// layer_output_collector: gathers one result per neuron into a frame, hands it downstream, restarts neurons.
// Optional watchdog abandons incomplete frames when COLLECTOR_TIMEOUT_EN is defined.
module layer_output_collector #(
   parameter int NUM_NEURONS = 5,
   parameter int DATA_WIDTH  = 23,
   parameter int TIMEOUT     = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   layer_output_collector_if.slave          bus,
   output logic                             neuron_rst,
   output logic                             busy,
   output logic                             timeout_err,
   output logic                             overrun
);
   localparam logic [1:0] COLLECT = 2'd0;
   localparam logic [1:0] PRESENT = 2'd1;
   localparam logic [1:0] RESTART = 2'd2;
   logic [1:0]                        state, state_nxt;
   logic [NUM_NEURONS-1:0]            mask, take, mask_nxt;
   logic [NUM_NEURONS*DATA_WIDTH-1:0] data_q;
   logic                              full, expire;
   assign take     = bus.in_valid & ~mask;
   assign mask_nxt = mask | take;
   assign full     = &mask_nxt;
`ifdef COLLECTOR_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   // the counter only runs while a partial frame is pending
   assign expire = (state == COLLECT) && (mask != '0) && !full && (cnt == CW'(TIMEOUT - 1));
   always_ff @(posedge clk) begin
      cnt         <= (rst || state != COLLECT || mask == '0) ? '0 : cnt + 1'b1;
      timeout_err <= !rst && expire;
   end
`else
   assign expire      = 1'b0;
   assign timeout_err = 1'b0;
`endif
   always_comb begin
      state_nxt = COLLECT;
      if (state == COLLECT) state_nxt = full ? PRESENT : expire ? RESTART : COLLECT;
      else if (state == PRESENT) state_nxt = bus.frame_ready ? RESTART : PRESENT;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= COLLECT;
         mask    <= '0;
         data_q  <= '0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nxt;
         mask    <= (state == RESTART) ? '0 : (state == COLLECT) ? mask_nxt : mask;
         overrun <= overrun | ((state == COLLECT) && |(bus.in_valid & mask))
                            | ((state == PRESENT) && |bus.in_valid);
         for (int i = 0; i < NUM_NEURONS; i++)
            if (state == COLLECT && take[i])
               data_q[i*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end
   assign bus.frame_data  = data_q;
   assign bus.frame_valid = (state == PRESENT);
   assign neuron_rst      = (state == RESTART);
   assign busy            = ((state == COLLECT) && (mask != '0)) || (state == PRESENT);
endmodule

// File: tb/tb_layer_output_collector.sv
// tb_layer_output_collector: directed scenario tests with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_layer_output_collector;
   localparam int N = 5;
   localparam int W = 23;
   logic clk = 1'b0;
   logic rst;
   logic neuron_rst, busy, timeout_err, overrun;
   int checks = 0;
   int errors = 0;
   layer_output_collector_if #(.NUM_NEURONS(N), .DATA_WIDTH(W)) bus ();
   layer_output_collector #(.NUM_NEURONS(N), .DATA_WIDTH(W), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .bus(bus), .neuron_rst(neuron_rst), .busy(busy),
      .timeout_err(timeout_err), .overrun(overrun)
   );
   always #5 clk = ~clk;
   function automatic logic [N*W-1:0] pack(input logic [W-1:0] a, b, c, d, e);
      return {e, d, c, b, a};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.in_valid = '0;
      bus.in_data  = '0;
   endtask
   task automatic do_reset();
      idle();
      bus.frame_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask
   task automatic test_reset();
      do_reset();
      checks += 6;
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got %b exp 0", bus.frame_valid); end
      if (bus.frame_data !== '0) begin errors++; $display("FAIL reset_frame_data got %h exp 0", bus.frame_data); end
      if (neuron_rst !== 1'b0) begin errors++; $display("FAIL reset_neuron_rst got %b exp 0", neuron_rst); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b exp 0", timeout_err); end
      if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
   endtask
   task automatic test_simultaneous();
      do_reset();
      bus.in_valid = 5'b11111;
      bus.in_data  = pack(23'h1, 23'h2, 23'h3, 23'h4, 23'h5);
      tick();
      idle();
      checks += 4;
      if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL sim_frame_valid got %b exp 1", bus.frame_valid); end
      if (bus.frame_data !== pack(23'h1, 23'h2, 23'h3, 23'h4, 23'h5)) begin errors++; $display("FAIL sim_frame_data got %h exp %h", bus.frame_data, pack(23'h1, 23'h2, 23'h3, 23'h4, 23'h5)); end
      if (busy !== 1'b1) begin errors++; $display("FAIL sim_busy got %b exp 1", busy); end
      if (overrun !== 1'b0) begin errors++; $display("FAIL sim_overrun got %b exp 0", overrun); end
      bus.frame_ready = 1'b1;
      tick();
      bus.frame_ready = 1'b0;
      checks += 2;
      if (neuron_rst !== 1'b1) begin errors++; $display("FAIL sim_neuron_rst got %b exp 1", neuron_rst); end
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL sim_valid_drop got %b exp 0", bus.frame_valid); end
      tick();
      checks += 2;
      if (neuron_rst !== 1'b0) begin errors++; $display("FAIL sim_neuron_rst_end got %b exp 0", neuron_rst); end
      if (busy !== 1'b0) begin errors++; $display("FAIL sim_busy_end got %b exp 0", busy); end
   endtask
   task automatic test_staggered();
      do_reset();
      bus.in_valid = 5'b10101;
      bus.in_data  = pack(23'h10, 23'h0, 23'h30, 23'h0, 23'h50);
      tick();
      checks += 3;
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL stag_valid1 got %b exp 0", bus.frame_valid); end
      if (busy !== 1'b1) begin errors++; $display("FAIL stag_busy got %b exp 1", busy); end
      if (bus.frame_data !== pack(23'h10, 23'h0, 23'h30, 23'h0, 23'h50)) begin errors++; $display("FAIL stag_partial got %h exp %h", bus.frame_data, pack(23'h10, 23'h0, 23'h30, 23'h0, 23'h50)); end
      bus.in_valid = 5'b00001;
      bus.in_data  = pack(23'h7FFFFF, 23'h0, 23'h0, 23'h0, 23'h0);
      tick();
      checks += 2;
      if (overrun !== 1'b1) begin errors++; $display("FAIL stag_overrun got %b exp 1", overrun); end
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL stag_valid2 got %b exp 0", bus.frame_valid); end
      bus.in_valid = 5'b01010;
      bus.in_data  = pack(23'h0, 23'h20, 23'h0, 23'h40, 23'h0);
      tick();
      idle();
      checks += 2;
      if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL stag_valid3 got %b exp 1", bus.frame_valid); end
      if (bus.frame_data !== pack(23'h10, 23'h20, 23'h30, 23'h40, 23'h50)) begin errors++; $display("FAIL stag_frame got %h exp %h", bus.frame_data, pack(23'h10, 23'h20, 23'h30, 23'h40, 23'h50)); end
   endtask
   task automatic test_backpressure();
      logic [N*W-1:0] exp_f;
      do_reset();
      exp_f = pack(23'h111111, 23'h222222, 23'h333333, 23'h444444, 23'h555555);
      bus.in_valid = 5'b11111;
      bus.in_data  = exp_f;
      tick();
      for (int c = 0; c < 10; c++) begin
         bus.in_valid = 5'b11111;
         bus.in_data  = pack(23'(c), 23'h7FFFFF, 23'h0, 23'h123, 23'h456);
         tick();
         checks += 2;
         if (bus.frame_data !== exp_f) begin errors++; $display("FAIL bp_hold cycle %0d got %h exp %h", c, bus.frame_data, exp_f); end
         if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d got %b exp 1", c, bus.frame_valid); end
      end
      idle();
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b exp 1", overrun); end
      bus.frame_ready = 1'b1;
      tick();
      checks += 2;
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %b exp 0", bus.frame_valid); end
      if (neuron_rst !== 1'b1) begin errors++; $display("FAIL bp_neuron_rst got %b exp 1", neuron_rst); end
      for (int c = 0; c < 3; c++) begin
         tick();
         checks += 3;
         if (neuron_rst !== 1'b0) begin errors++; $display("FAIL bp_idle_rst cycle %0d got %b exp 0", c, neuron_rst); end
         if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_valid cycle %0d got %b exp 0", c, bus.frame_valid); end
         if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy cycle %0d got %b exp 0", c, busy); end
      end
      bus.frame_ready = 1'b0;
   endtask
`ifdef COLLECTOR_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      bus.in_valid = 5'b01111;
      bus.in_data  = pack(23'h1, 23'h2, 23'h3, 23'h4, 23'h0);
      tick();
      idle();
      for (int k = 1; k < 16; k++) begin
         tick();
         checks += 2;
         if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early_err k=%0d got %b exp 0", k, timeout_err); end
         if (neuron_rst !== 1'b0) begin errors++; $display("FAIL to_early_rst k=%0d got %b exp 0", k, neuron_rst); end
      end
      tick();
      checks += 3;
      if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", timeout_err); end
      if (neuron_rst !== 1'b1) begin errors++; $display("FAIL to_neuron_rst got %b exp 1", neuron_rst); end
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL to_valid got %b exp 0", bus.frame_valid); end
      tick();
      checks += 2;
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_end got %b exp 0", timeout_err); end
      if (busy !== 1'b0) begin errors++; $display("FAIL to_mask_empty got %b exp 0", busy); end
      bus.in_valid = 5'b10000;
      bus.in_data  = pack(23'h0, 23'h0, 23'h0, 23'h0, 23'h9);
      tick();
      idle();
      checks++;
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL to_lane4_only got %b exp 0", bus.frame_valid); end
   endtask
`else
   task automatic test_no_timeout();
      do_reset();
      bus.in_valid = 5'b01111;
      bus.in_data  = pack(23'h1, 23'h2, 23'h3, 23'h4, 23'h0);
      tick();
      idle();
      for (int k = 0; k < 100; k++) begin
         tick();
         checks += 2;
         if (timeout_err !== 1'b0) begin errors++; $display("FAIL nto_err k=%0d got %b exp 0", k, timeout_err); end
         if (busy !== 1'b1) begin errors++; $display("FAIL nto_busy k=%0d got %b exp 1", k, busy); end
      end
      bus.in_valid = 5'b10000;
      bus.in_data  = pack(23'h0, 23'h0, 23'h0, 23'h0, 23'h5);
      tick();
      idle();
      checks += 2;
      if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL nto_valid got %b exp 1", bus.frame_valid); end
      if (bus.frame_data !== pack(23'h1, 23'h2, 23'h3, 23'h4, 23'h5)) begin errors++; $display("FAIL nto_frame got %h exp %h", bus.frame_data, pack(23'h1, 23'h2, 23'h3, 23'h4, 23'h5)); end
   endtask
`endif
   task automatic test_reset_mid_frame();
      do_reset();
      bus.in_valid = 5'b11111;
      bus.in_data  = pack(23'hA, 23'hB, 23'hC, 23'hD, 23'hE);
      tick();
      bus.in_valid = 5'b00100;
      tick();
      idle();
      checks += 2;
      if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL rmf_valid got %b exp 1", bus.frame_valid); end
      if (overrun !== 1'b1) begin errors++; $display("FAIL rmf_overrun_set got %b exp 1", overrun); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks += 4;
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL rmf_valid_clr got %b exp 0", bus.frame_valid); end
      if (bus.frame_data !== '0) begin errors++; $display("FAIL rmf_data_clr got %h exp 0", bus.frame_data); end
      if (overrun !== 1'b0) begin errors++; $display("FAIL rmf_overrun_clr got %b exp 0", overrun); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rmf_busy_clr got %b exp 0", busy); end
      bus.in_valid = 5'b11111;
      bus.in_data  = pack(23'h6, 23'h7, 23'h8, 23'h9, 23'h3FFFFF);
      tick();
      idle();
      checks += 2;
      if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL rmf_new_valid got %b exp 1", bus.frame_valid); end
      if (bus.frame_data !== pack(23'h6, 23'h7, 23'h8, 23'h9, 23'h3FFFFF)) begin errors++; $display("FAIL rmf_new_frame got %h exp %h", bus.frame_data, pack(23'h6, 23'h7, 23'h8, 23'h9, 23'h3FFFFF)); end
   endtask
   task automatic test_back_to_back();
      do_reset();
      bus.frame_ready = 1'b1;
      bus.in_valid = 5'b11111;
      bus.in_data  = pack(23'h21, 23'h22, 23'h23, 23'h24, 23'h25);
      tick();
      idle();
      checks++;
      if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got %b exp 1", bus.frame_valid); end
      tick();
      checks++;
      if (neuron_rst !== 1'b1) begin errors++; $display("FAIL b2b_rst got %b exp 1", neuron_rst); end
      bus.in_valid = 5'b00011;
      bus.in_data  = pack(23'h7FFFFF, 23'h7FFFFF, 23'h0, 23'h0, 23'h0);
      tick();
      idle();
      checks += 3;
      if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_restart_drop_overrun got %b exp 0", overrun); end
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_restart_drop_busy got %b exp 0", busy); end
      if (neuron_rst !== 1'b0) begin errors++; $display("FAIL b2b_rst_end got %b exp 0", neuron_rst); end
      bus.in_valid = 5'b11111;
      bus.in_data  = pack(23'h31, 23'h32, 23'h33, 23'h34, 23'h35);
      tick();
      idle();
      checks += 2;
      if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2 got %b exp 1", bus.frame_valid); end
      if (bus.frame_data !== pack(23'h31, 23'h32, 23'h33, 23'h34, 23'h35)) begin errors++; $display("FAIL b2b_frame2 got %h exp %h", bus.frame_data, pack(23'h31, 23'h32, 23'h33, 23'h34, 23'h35)); end
      bus.frame_ready = 1'b0;
   endtask
   initial begin
      rst = 1'b1;
      idle();
      bus.frame_ready = 1'b0;
      test_reset();
      test_simultaneous();
      test_staggered();
      test_backpressure();
`ifdef COLLECTOR_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_mid_frame();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/layer_output_collector.md
# layer_output_collector

Receives per-neuron results from a layer of `neuron` instances, each emitting a one-cycle `out_valid` pulse with `out_data`. Captures one result per neuron into a frame, presents the packed frame downstream on a valid/ready handshake, then pulses a restart to the neurons for the next inference. Sits between a hidden layer and the next layer or readout logic.

## Interface
- `NUM_NEURONS`, default 5: number of neuron lanes.
- `DATA_WIDTH`, default 23: width of each neuron result (matches neuron `OUT_WIDTH`).
- `TIMEOUT`, default 16: maximum number of cycles from the first capture to a complete frame.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in NUM_NEURONS*DATA_WIDTH: lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `in_valid` in NUM_NEURONS: per-lane valid pulse from the neurons.
- `frame_data` out NUM_NEURONS*DATA_WIDTH: captured frame, same packing as `in_data`.
- `frame_valid` out 1: frame available.
- `frame_ready` in 1: downstream accepts the frame.
- `neuron_rst` out 1: one-cycle restart pulse to all neurons.
- `busy` out 1: high in COLLECT with at least one lane captured, and in PRESENT.
- `timeout_err` out 1: one-cycle pulse when a frame is abandoned.
- `overrun` out 1: sticky; set when a pulse is dropped; cleared only by `rst`.

## Operation
- State machine states:
  - COLLECT (reset state)
  - PRESENT
  - RESTART
- COLLECT:
  - For each lane with `in_valid[i]=1` and `mask[i]=0`: latch `in_data` lane i into `frame_data` lane i and set `mask[i]`.
  - A pulse on a lane already masked is dropped and sets `overrun`; the first captured value is kept.
  - Any number of lanes may capture in the same cycle.
  - When the mask becomes all ones, including within the capturing cycle, go to PRESENT.
- PRESENT:
  - `frame_valid=1`; `frame_data` is held stable.
  - Every `in_valid` pulse is dropped and sets `overrun`.
  - On `frame_valid && frame_ready`, go to RESTART.
- RESTART:
  - Lasts one cycle, with `neuron_rst=1`.
  - Clear the mask and go to COLLECT.
  - `in_valid` pulses in this cycle are dropped without setting `overrun`, because the neurons are being reset.
- Watchdog (when compiled in):
  - A cycle counter clears in COLLECT while the mask is zero, and increments each COLLECT cycle once the mask is non-zero.
  - If the counter reaches `TIMEOUT` before the mask is full: pulse `timeout_err` and go to RESTART.
  - The partial frame is discarded and `frame_valid` never asserts for it.
- Data is passed through unmodified; there is no arithmetic on lane contents.
- `rst` at any time, including mid-PRESENT:
  - State goes to COLLECT; mask, counter, `frame_data`, `overrun` and all outputs clear.
  - A pending frame is lost.

## Timing
- Reset values:
  - `frame_data=0`, `frame_valid=0`, `neuron_rst=0`, `busy=0`, `timeout_err=0`, `overrun=0`.
- Capture is registered: a lane pulsed at edge N is visible on `frame_data` after edge N.
- Last lane captured at edge N gives `frame_valid=1` after edge N (one-cycle latency).
- `frame_valid` deasserts the cycle after the handshake edge.
- `neuron_rst` is high for exactly the cycle following the handshake.
- `frame_ready` while `frame_valid=0` is ignored.
- `frame_ready` may be held high permanently; minimum frame period is collect time + 2 cycles.
- `timeout_err` and `neuron_rst` are both asserted in the same RESTART cycle after a timeout.

## Configuration
- `COLLECTOR_TIMEOUT_EN`:
  - Defined: the watchdog counter, `TIMEOUT` handling and `timeout_err` pulses are built.
  - Undefined: no counter is built; COLLECT waits indefinitely for all lanes; `timeout_err` is tied to 0; the `TIMEOUT` parameter is ignored.

## Test plan
- **Simultaneous capture.** Reset, then `in_valid=5'b11111` with lanes 0x000001..0x000005 for one cycle → next cycle `frame_valid=1` and `frame_data` lanes = 1..5. `frame_ready=1` → `neuron_rst` pulses 1 cycle, then `busy=0`.
- **Staggered capture and duplicate.** Pulse lanes 0,2,4 at cycle 1 and lanes 1,3 at cycle 3 → `frame_valid` rises after cycle 3. A second pulse on lane 0 at cycle 2 with value 0x7FFFFF → lane 0 keeps its first value and `overrun=1`.
- **Backpressure.** Complete a frame, hold `frame_ready=0` for 10 cycles while pulsing `in_valid` → `frame_data` unchanged, `overrun=1`. Raise `frame_ready` → single handshake, then `neuron_rst` pulse.
- **Timeout (`COLLECTOR_TIMEOUT_EN`, TIMEOUT=16).** Pulse lanes 0–3 only → `timeout_err` and `neuron_rst` pulse 16 cycles after the first capture; `frame_valid` stays 0; the mask is empty afterwards.
- **No timeout (macro undefined).** Same stimulus → no `timeout_err` after 100 cycles. A late lane 4 pulse → `frame_valid=1`.
- **Reset mid-frame.** Assert `rst` in PRESENT → next cycle `frame_valid=0`, `frame_data=0`, `overrun=0`. A new full capture works normally.
